// File: rtl/lod_share_scheduler.sv
// Round-robin scheduler that time-shares one registered 32-bit leading-one detector
// among NUM_REQ lanes, with per-lane request/response handshakes and one result slot per lane.
module lod_share_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 32,
  parameter int LOC_W   = 6
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*WORD_W-1:0] reqWord,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic [NUM_REQ-1:0]        rspValid,
  output logic [NUM_REQ*LOC_W-1:0]  rspLoc,
  input  logic [NUM_REQ-1:0]        rspReady,
  output logic [WORD_W-1:0]         lodWord,
  input  logic [LOC_W-1:0]          lodLoc,
  output logic                      busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]         rrPtr_q, rrPtr_d;
  logic [TAG_W-1:0]         s1Tag_q, s2Tag_q;
  logic                     s1V_q, s2V_q;
  logic [WORD_W-1:0]        lodWord_q;
  logic [NUM_REQ-1:0]       rspValid_q;
  logic [NUM_REQ*LOC_W-1:0] rspLoc_q;

  logic [NUM_REQ-1:0]       eligible;
  logic [TAG_W-1:0]         grantIdx;
  logic [TAG_W-1:0]         cand;
  logic                     grantFound;

  // A lane may issue only when it has nothing in the pipe and its slot will be free on arrival.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reqValid[i]
                  & !(s1V_q && (s1Tag_q == TAG_W'(i)))
                  & !(s2V_q && (s2Tag_q == TAG_W'(i)))
                  & (!rspValid_q[i] | rspReady[i]);
    end
  end

  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    reqReady   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = TAG_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!grantFound && eligible[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
    if (grantFound && rstN) begin
      reqReady[grantIdx] = 1'b1;
    end
    if (!grantFound) begin
      rrPtr_d = rrPtr_q;
    end else if (grantIdx == TAG_W'(NUM_REQ - 1)) begin
      rrPtr_d = '0;
    end else begin
      rrPtr_d = grantIdx + 1'b1;
    end
  end

  // A slot refill in the same edge as its consumption wins over the clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rrPtr_q    <= '0;
      s1Tag_q    <= '0;
      s2Tag_q    <= '0;
      s1V_q      <= 1'b0;
      s2V_q      <= 1'b0;
      lodWord_q  <= '0;
      rspValid_q <= '0;
      rspLoc_q   <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      s1V_q   <= grantFound;
      if (grantFound) begin
        lodWord_q <= reqWord[grantIdx*WORD_W +: WORD_W];
        s1Tag_q   <= grantIdx;
      end
      s2V_q   <= s1V_q;
      s2Tag_q <= s1Tag_q;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rspValid_q[i] && rspReady[i]) begin
          rspValid_q[i] <= 1'b0;
        end
      end
      if (s2V_q) begin
        rspValid_q[s2Tag_q]                 <= 1'b1;
        rspLoc_q[s2Tag_q*LOC_W +: LOC_W]    <= lodLoc;
      end
    end
  end

  slotOverwrite : assert property (@(posedge clk) disable iff (!rstN)
    s2V_q |-> (!rspValid_q[s2Tag_q] || rspReady[s2Tag_q]));

  assign lodWord  = lodWord_q;
  assign rspValid = rspValid_q;
  assign rspLoc   = rspLoc_q;
  assign busy     = s1V_q | s2V_q | (|rspValid_q);

endmodule
